// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder: one shared 4-bit full adder processes one
// nibble per clock, least-significant first, with the carry registered between nibbles.

module FA_4bits (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       carry
);

  assign {carry, sum} = {1'b0, a} + {1'b0, b} + {4'b0000, cin};

endmodule

module nibble_serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_carry,
  output logic             busy
);

  localparam int N     = WIDTH / 4;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

  state_t             state, state_next;
  logic [WIDTH-1:0]   a_q, b_q, sum_q;
  logic               carry_q, carry_out_q;
  logic [IDX_W-1:0]   idx;
  logic [3:0]         fa_a, fa_b, fa_sum;
  logic               fa_carry;
  logic               last_nibble;
  logic               accept;

  assign in_ready    = (state == IDLE) && !rst;
  assign out_valid   = (state == DONE);
  assign busy        = (state != IDLE);
  assign accept      = in_valid && in_ready;
  assign last_nibble = (idx == IDX_W'(N - 1));
  assign out_sum     = sum_q;
  assign out_carry   = carry_out_q;

  // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    fa_a = '0;
    fa_b = '0;
    for (int i = 0; i < N; i++) begin
      if (idx == IDX_W'(i)) begin
        fa_a = a_q[4*i +: 4];
        fa_b = b_q[4*i +: 4];
      end
    end
  end

  FA_4bits u_fa (
    .a     (fa_a),
    .b     (fa_b),
    .cin   (carry_q),
    .sum   (fa_sum),
    .carry (fa_carry)
  );

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept)      state_next = ADD;
      ADD:     if (last_nibble) state_next = DONE;
      DONE:    if (out_ready)   state_next = IDLE;
      default:                  state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // NOTE: operand storage carries no reset; it is always loaded at accept before ADD reads it.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_q <= in_a;
      b_q <= in_b;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q       <= '0;
      carry_out_q <= 1'b0;
      carry_q     <= 1'b0;
      idx         <= '0;
    end else if (accept) begin
      carry_q <= in_cin;
      idx     <= '0;
    end else if (state == ADD) begin
      for (int i = 0; i < N; i++) begin
        if (idx == IDX_W'(i)) sum_q[4*i +: 4] <= fa_sum;
      end
      carry_q <= fa_carry;
      idx     <= idx + IDX_W'(1);
      if (last_nibble) carry_out_q <= fa_carry;
    end
  end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed bench for nibble_serial_adder (WIDTH = 16): each scenario task
// drives its stimulus at the falling edge and compares outputs there.

module tb_nibble_serial_adder;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic        in_cin;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_sum;
  logic        out_carry;
  logic        busy;

  int errors = 0;
  int checks = 0;

  nibble_serial_adder #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_carry (out_carry),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Called at a falling edge; returns at the falling edge after the accept edge.
  task automatic accept_op(input logic [15:0] a, input logic [15:0] b, input logic cin,
                           output bit ok);
    ok = 1'b0;
    in_a = a; in_b = b; in_cin = cin; in_valid = 1'b1;
    for (int i = 0; i < 20 && !ok; i++) begin
      ok = in_ready;
      @(posedge clk);
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  // Counts rising edges from the accept edge until out_valid is seen.
  task automatic wait_done(output bit ok, output int edges);
    ok = 1'b0;
    edges = 0;
    for (int i = 0; i < 30 && !ok; i++) begin
      if (out_valid) ok = 1'b1;
      else begin
        @(posedge clk);
        edges++;
        @(negedge clk);
      end
    end
  endtask

  task automatic take_result();
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    bit ok;
    bit seen;
    accept_op(16'h1357, 16'h2468, 1'b0, ok);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++; $display("FAIL reset_in_ready_async: got %b want 0", in_ready);
    end
    for (int c = 0; c < 2; c++) begin
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || out_sum !== 16'h0000 ||
          out_carry !== 1'b0 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL reset_state[%0d]: valid=%b busy=%b sum=%h carry=%b ready=%b want 0 0 0000 0 0",
                 c, out_valid, busy, out_sum, out_carry, in_ready);
      end
    end
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_release_ready: got %b want 1", in_ready);
    end
    seen = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++; $display("FAIL reset_abandon: out_valid seen=%b want 0", seen);
    end
  endtask

  task automatic test_basic_add();
    bit ok;
    bit busy_bad;
    int edges;
    accept_op(16'h1234, 16'h1111, 1'b0, ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL basic_accept: accepted=%b want 1", ok);
    end
    busy_bad = 1'b0;
    edges = 0;
    while (!out_valid && edges < 30) begin
      if (busy !== 1'b1) busy_bad = 1'b1;
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    checks++;
    if (edges !== 4) begin
      errors++; $display("FAIL basic_latency: got %0d edges want 4", edges);
    end
    checks++;
    if (busy_bad !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL basic_busy: busy dropped=%b busy=%b want 0 1", busy_bad, busy);
    end
    checks++;
    if (out_sum !== 16'h2345 || out_carry !== 1'b0) begin
      errors++; $display("FAIL basic_result: got %h/%b want 2345/0", out_sum, out_carry);
    end
    take_result();
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_release: busy=%b ready=%b valid=%b want 0 1 0", busy, in_ready, out_valid);
    end
  endtask

  task automatic test_carry_ripple();
    logic [15:0] va [2] = '{16'hFFFF, 16'hFFFF};
    logic [15:0] vb [2] = '{16'h0000, 16'hFFFF};
    logic [15:0] es [2] = '{16'h0000, 16'hFFFF};
    bit ok;
    int edges;
    for (int v = 0; v < 2; v++) begin
      accept_op(va[v], vb[v], 1'b1, ok);
      wait_done(ok, edges);
      checks++;
      if (!ok || out_sum !== es[v] || out_carry !== 1'b1) begin
        errors++;
        $display("FAIL ripple[%0d]: done=%b got %h/%b want %h/1", v, ok, out_sum, out_carry, es[v]);
      end
      take_result();
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    int edges;
    accept_op(16'h8000, 16'h8000, 1'b0, ok);
    wait_done(ok, edges);
    checks++;
    if (!ok || out_sum !== 16'h0000 || out_carry !== 1'b1) begin
      errors++; $display("FAIL bp_first: done=%b got %h/%b want 0000/1", ok, out_sum, out_carry);
    end
    in_a = 16'h0001; in_b = 16'h0001; in_cin = 1'b0; in_valid = 1'b1;
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_sum !== 16'h0000 || out_carry !== 1'b1 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold[%0d]: valid=%b sum=%h carry=%b ready=%b want 1 0000 1 0",
                 c, out_valid, out_sum, out_carry, in_ready);
      end
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL bp_release: valid=%b ready=%b want 0 1", out_valid, in_ready);
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    wait_done(ok, edges);
    checks++;
    if (!ok || edges !== 4 || out_sum !== 16'h0002 || out_carry !== 1'b0) begin
      errors++;
      $display("FAIL bp_second: done=%b edges=%0d got %h/%b want 1 4 0002/0", ok, edges, out_sum, out_carry);
    end
    take_result();
  endtask

  task automatic test_back_to_back();
    logic [15:0] va [2] = '{16'h0F0F, 16'h7FFF};
    logic [15:0] vb [2] = '{16'h00F1, 16'h0001};
    logic [15:0] es [2] = '{16'h1000, 16'h8000};
    int acc_cyc [2];
    logic [15:0] got_sum [2];
    logic got_carry [2];
    int k = 0;
    int r = 0;
    int cyc = 0;
    in_a = va[0]; in_b = vb[0]; in_cin = 1'b0; in_valid = 1'b1;
    out_ready = 1'b1;
    while (r < 2 && cyc < 40) begin
      if (in_valid && in_ready && k < 2) begin
        acc_cyc[k] = cyc;
        k++;
      end
      if (out_valid && r < 2) begin
        got_sum[r] = out_sum;
        got_carry[r] = out_carry;
        r++;
      end
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (k < 2) begin
        in_a = va[k]; in_b = vb[k];
      end else begin
        in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    checks++;
    if (r !== 2 || k !== 2) begin
      errors++; $display("FAIL b2b_timeout: results=%0d accepts=%0d want 2 2", r, k);
    end else begin
      for (int v = 0; v < 2; v++) begin
        checks++;
        if (got_sum[v] !== es[v] || got_carry[v] !== 1'b0) begin
          errors++;
          $display("FAIL b2b_result[%0d]: got %h/%b want %h/0", v, got_sum[v], got_carry[v], es[v]);
        end
      end
      checks++;
      if (acc_cyc[1] - acc_cyc[0] !== 6) begin
        errors++; $display("FAIL b2b_spacing: got %0d cycles want 6", acc_cyc[1] - acc_cyc[0]);
      end
    end
  endtask

  task automatic test_reset_mid_add();
    bit ok;
    bit seen;
    int edges;
    out_ready = 1'b1;
    accept_op(16'hAAAA, 16'h5555, 1'b0, ok);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 8; c++) begin
      if (out_valid) seen = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++; $display("FAIL midadd_no_result: out_valid seen=%b want 0", seen);
    end
    out_ready = 1'b0;
    accept_op(16'h00FF, 16'h0001, 1'b0, ok);
    wait_done(ok, edges);
    checks++;
    if (!ok || out_sum !== 16'h0100 || out_carry !== 1'b0) begin
      errors++; $display("FAIL midadd_next: done=%b got %h/%b want 0100/0", ok, out_sum, out_carry);
    end
    take_result();
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    in_a = '0;
    in_b = '0;
    in_cin = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    test_reset();
    test_basic_add();
    test_carry_ripple();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_add();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
